// File: rtl/tick_pause_ctrl.sv
// Button-driven tick/pause/mode controller for the LED pattern processors.
// Optional auto-resume of pause after a timeout is enabled by defining AUTO_RESUME_EN.
module tick_pause_ctrl #(
    parameter int TICK_DIV      = 25000000,
    parameter int DB_CYCLES     = 500000,
    parameter int PAUSE_TIMEOUT = 250000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_pause,
    input  logic       btn_mode,
    output logic       tick,
    output logic       pause,
    output logic [1:0] mode,
    output logic       mode_change
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

    if (TICK_DIV < 2 || DB_CYCLES < 2 || PAUSE_TIMEOUT < 2) begin : g_param_check
        $error("tick_pause_ctrl: TICK_DIV, DB_CYCLES and PAUSE_TIMEOUT must all be >= 2");
    end

    // Index 0 is the pause button, index 1 the mode button.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      stable_q, stable_d, stable_dly_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    logic             tick_q, tick_d;
    logic             pause_q, pause_d;
    logic [1:0]       mode_q, mode_d;
    logic             mode_change_q, mode_change_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             press_pause, press_mode;

`ifdef AUTO_RESUME_EN
    localparam int TO_W = (PAUSE_TIMEOUT > 2) ? $clog2(PAUSE_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(PAUSE_TIMEOUT - 1);
    logic [TO_W-1:0] to_q, to_d;
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    assign press_pause = stable_q[0] & ~stable_dly_q[0];
    assign press_mode  = stable_q[1] & ~stable_dly_q[1];

    always_comb begin
        mode_d        = mode_q;
        mode_change_d = 1'b0;
        pause_d       = pause_q;
        div_d         = div_q;
        tick_d        = 1'b0;

        // A mode press overrides any pause press or timeout in the same cycle.
        if (press_mode) begin
            mode_d        = mode_q + 2'd1;
            mode_change_d = 1'b1;
            pause_d       = 1'b0;
`ifdef AUTO_RESUME_EN
        end else if (pause_q && to_q == TO_LAST) begin
            pause_d = 1'b0;
`endif
        end else if (press_pause) begin
            pause_d = ~pause_q;
        end

        // Gating on both pause_q and pause_d holds the count on the edge pause asserts.
        if (press_mode) begin
            div_d = '0;
        end else if (!pause_q && !pause_d) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

`ifdef AUTO_RESUME_EN
        to_d = (pause_q && pause_d) ? to_q + 1'b1 : '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_dly_q  <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
            tick_q        <= 1'b0;
            pause_q       <= 1'b0;
            mode_q        <= '0;
            mode_change_q <= 1'b0;
            div_q         <= '0;
`ifdef AUTO_RESUME_EN
            to_q          <= '0;
`endif
        end else begin
            sync1_q       <= {btn_mode, btn_pause};
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_dly_q  <= stable_q;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
            tick_q        <= tick_d;
            pause_q       <= pause_d;
            mode_q        <= mode_d;
            mode_change_q <= mode_change_d;
            div_q         <= div_d;
`ifdef AUTO_RESUME_EN
            to_q          <= to_d;
`endif
        end
    end

    assign tick        = tick_q;
    assign pause       = pause_q;
    assign mode        = mode_q;
    assign mode_change = mode_change_q;

endmodule

// File: tb/tb_tick_pause_ctrl.sv
// Directed bench for tick_pause_ctrl with TICK_DIV=4, DB_CYCLES=3, PAUSE_TIMEOUT=20.
// Defining AUTO_RESUME_EN switches the final scenario to expect the timeout resume.
module tb_tick_pause_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_pause;
    logic       btn_mode;
    logic       tick;
    logic       pause;
    logic [1:0] mode;
    logic       mode_change;

    int checks = 0;
    int errors = 0;
    int ticks;

    tick_pause_ctrl #(
        .TICK_DIV      (4),
        .DB_CYCLES     (3),
        .PAUSE_TIMEOUT (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_pause   (btn_pause),
        .btn_mode    (btn_mode),
        .tick        (tick),
        .pause       (pause),
        .mode        (mode),
        .mode_change (mode_change)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Button held from now: press edge lands on the 6th clock (2 sync + 3 debounce + 1).
    task automatic press_mode(input logic [1:0] exp_mode);
        btn_mode = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("mode_change_pre", {31'd0, mode_change}, 32'd0);
        end
        step();
        chk("mode_adv", {30'd0, mode}, {30'd0, exp_mode});
        chk("mode_change_pulse", {31'd0, mode_change}, 32'd1);
        chk("mode_forces_unpause", {31'd0, pause}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        btn_pause = 1'b0;
        btn_mode  = 1'b0;
        step();
        step();
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_pause", {31'd0, pause}, 32'd0);
        chk("rst_mode", {30'd0, mode}, 32'd0);
        chk("rst_mode_change", {31'd0, mode_change}, 32'd0);
        reset = 1'b0;

        // Idle: tick on every 4th cycle, first one 4 cycles after reset release
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("idle_tick", {31'd0, tick}, {31'd0, (i % 4 == 0)});
            chk("idle_pause", {31'd0, pause}, 32'd0);
            chk("idle_mode", {30'd0, mode}, 32'd0);
            chk("idle_mode_change", {31'd0, mode_change}, 32'd0);
        end

        // Pause press held 10 cycles; divider is at 1 when pause lands
        btn_pause = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("pause_enter", {31'd0, pause}, {31'd0, (i >= 6)});
            chk("pause_enter_tick", {31'd0, tick}, {31'd0, (i == 4)});
        end
        btn_pause = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("paused_hold", {31'd0, pause}, 32'd1);
            chk("paused_no_tick", {31'd0, tick}, 32'd0);
        end

        // Second press resumes from held count 1: tick 3 edges after resume
        btn_pause = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("pause_exit", {31'd0, pause}, {31'd0, (i < 6)});
            chk("resume_phase_tick", {31'd0, tick}, {31'd0, (i == 9)});
        end
        btn_pause = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("release_no_event", {31'd0, pause}, 32'd0);
        end

        // Two-cycle glitch is rejected
        btn_pause = 1'b1;
        step();
        step();
        btn_pause = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("glitch_pause", {31'd0, pause}, 32'd0);
        end
        chk("glitch_db_cnt", 32'(dut.db_cnt_q[0]), 32'd0);

        // Four clean mode presses wrap 1,2,3,0
        for (int m = 1; m <= 4; m++) begin
            press_mode(2'(m % 4));
            step();
            chk("mode_change_single", {31'd0, mode_change}, 32'd0);
            btn_mode = 1'b0;
            repeat (6) step();
        end

        // Mode press while paused: unpause and restart divider
        btn_pause = 1'b1;
        repeat (6) step();
        chk("pause_before_mode", {31'd0, pause}, 32'd1);
        btn_pause = 1'b0;
        repeat (6) step();
        press_mode(2'd1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("restart_tick", {31'd0, tick}, {31'd0, (i == 4)});
            chk("restart_mode_change", {31'd0, mode_change}, 32'd0);
        end
        btn_mode = 1'b0;
        repeat (6) step();

        // Simultaneous pause and mode press: mode wins, pause press discarded
        btn_pause = 1'b1;
        press_mode(2'd2);
        step();
        chk("simul_mode_change", {31'd0, mode_change}, 32'd0);
        chk("simul_pause", {31'd0, pause}, 32'd0);
        btn_pause = 1'b0;
        btn_mode  = 1'b0;
        repeat (6) step();
        chk("simul_pause_after", {31'd0, pause}, 32'd0);
        chk("simul_mode_after", {30'd0, mode}, 32'd2);

        // Reset mid-debounce discards progress
        btn_pause = 1'b1;
        repeat (3) step();
        reset     = 1'b1;
        btn_pause = 1'b0;
        step();
        chk("midrst_tick", {31'd0, tick}, 32'd0);
        chk("midrst_pause", {31'd0, pause}, 32'd0);
        chk("midrst_mode", {30'd0, mode}, 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("postrst_pause", {31'd0, pause}, 32'd0);
            chk("postrst_mode_change", {31'd0, mode_change}, 32'd0);
            if (i <= 3) chk("postrst_tick", {31'd0, tick}, 32'd0);
        end

        // Enter pause and leave the buttons alone
        btn_pause = 1'b1;
        repeat (6) step();
        chk("final_pause_enter", {31'd0, pause}, 32'd1);
        btn_pause = 1'b0;
        repeat (6) step();
        ticks = 0;
`ifdef AUTO_RESUME_EN
        repeat (13) step();
        chk("auto_still_paused", {31'd0, pause}, 32'd1);
        step();
        chk("auto_resumed", {31'd0, pause}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step();
            ticks += int'(tick);
        end
        chk("auto_ticks", 32'(ticks), 32'd2);
`else
        for (int i = 1; i <= 100; i++) begin
            step();
            ticks += int'(tick);
        end
        chk("no_auto_pause", {31'd0, pause}, 32'd1);
        chk("no_auto_ticks", 32'(ticks), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_pause_ctrl.md
Name: tick_pause_ctrl

Overview:
- Control-side driver for the LED pattern processors: produces the `tick` step strobe, the `pause` level and the 2-bit `mode` select.
- Processors consume these and hold their pattern while `pause`=1.
- Inputs are two raw push-buttons (pause toggle, mode advance), synchronised and debounced inside this block.
- Sits between the board buttons and the four mode processors / output mux.

Parameters:
- TICK_DIV, 25000000, clk cycles per tick period (>=2).
- DB_CYCLES, 500000, cycles a synchronised button level must hold before it is accepted (>=2).
- PAUSE_TIMEOUT, 250000000, clk cycles before auto-resume (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_pause  in  1  raw pause button, active-high, asynchronous to clk.
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk.
- tick  out  1  one-cycle step strobe.
- pause  out  1  pause level, 1 = processors hold.
- mode  out  2  selected mode, 0..3.
- mode_change  out  1  one-cycle pulse when mode updates.

Behaviour:
- One clock (clk). Reset is synchronous and active-high, sampled on the rising edge of clk; all registers clear on that edge.
- Reset values:
  - tick=0, pause=0, mode=0, mode_change=0.
  - Divider=0, debounce counters=0, stable levels=0, synchroniser flops=0.
- Synchroniser: each button passes through two flops before any other use.
- Debouncer (one per button):
  - Counter increments while the synchronised level differs from the stable level.
  - Counter clears to 0 on any cycle they are equal.
  - When the counter equals DB_CYCLES-1 and the levels still differ: stable level takes the synchronised value and the counter clears.
  - Press = stable level rising (stable 0->1), one cycle wide, combinational from the stable register and its one-cycle delay.
  - Release produces no event.
- Pause toggle:
  - On a pause press, `pause` inverts on the next clk edge.
  - Latency from a clean button rise: 2 sync cycles + DB_CYCLES + 1 cycles to the pause change.
- Mode advance:
  - On a mode press, `mode` <= mode+1 mod 4 (3 wraps to 0).
  - On the same edge: `mode_change` is 1 for exactly that cycle, `pause` is forced to 0, and the divider clears to 0.
- Simultaneous pause and mode press in the same cycle: the mode press wins. Mode advances and pause=0; the pause press is discarded.
- Tick divider:
  - Counts 0..TICK_DIV-1 while pause=0.
  - `tick`=1 for one cycle, registered, on the cycle after the counter reaches TICK_DIV-1; the counter wraps to 0 on that edge.
  - While pause=1: the counter holds its value and tick=0.
  - On resume, counting continues from the held value, so the partial period is preserved.
- Pause asserting in the same cycle the counter hits TICK_DIV-1: that tick is suppressed and the counter holds at TICK_DIV-1. The first tick after resume is 1 cycle later.
- Reset mid-debounce or mid-period: all progress is discarded; no tick or press is emitted on the reset edge or the cycle after.
- Button held indefinitely: exactly one press. A new press requires a debounced release then a debounced rise.

Optional Feature:
- Macro: AUTO_RESUME_EN.
- Defined:
  - A timeout counter increments every cycle while pause=1 and clears whenever pause=0.
  - When it reaches PAUSE_TIMEOUT-1, `pause` clears on the next edge; the divider then resumes from its held value.
  - A pause press on that same cycle also yields pause=0, with no double toggle.
- Undefined: no timeout counter; pause persists until a press, a mode press or reset.

Test Plan (TICK_DIV=4, DB_CYCLES=3, PAUSE_TIMEOUT=20):
- Reset, idle 20 cycles -> tick every 4th cycle, first tick 4 cycles after reset release; pause=0, mode=0, mode_change=0 throughout.
- btn_pause 1 held 10 cycles -> pause=1 exactly 2+3+1=6 cycles after the rise, no ticks while paused; second press -> pause=0 and ticks resume with the preserved phase.
- btn_pause glitch 1 for 2 cycles then 0 -> no pause change, debounce counter returns to 0.
- Four clean mode presses -> mode 1,2,3,0, one mode_change pulse per press; press while paused -> pause=0, divider restarts, next tick 4 cycles later.
- Pause and mode debounced rises on the same cycle -> mode+1, pause=0, single mode_change pulse; reset asserted mid-debounce -> no press event.
- With AUTO_RESUME_EN: enter pause, no further input -> pause=0 after 20 cycles, ticks resume; without the macro, pause still 1 after 100 cycles.
